// File: rtl/link_mm_arbiter_if.sv
// Bus bundle between the MM requesters, link_mm_arbiter and the link address decoder.
// master: arbiter view; slave: the surrounding requesters/decoder view.
interface link_mm_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 64
);
  logic [N_REQ-1:0]        req_wr_en;
  logic [N_REQ-1:0]        req_rd_en;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wr_data;
  logic [N_REQ-1:0]        req_gnt;
  logic [DATA_W-1:0]       req_rd_data;
  logic [N_REQ-1:0]        req_rd_data_v;
  logic                    mm_wr_en;
  logic                    mm_rd_en;
  logic [ADDR_W-1:0]       mm_addr;
  logic [DATA_W-1:0]       mm_wr_data;
  logic [DATA_W-1:0]       mm_rd_data;
  logic                    mm_rd_data_v;
  logic [15:0]             timeout_cnt;

  modport master (
    input  req_wr_en, req_rd_en, req_addr, req_wr_data, mm_rd_data, mm_rd_data_v,
    output req_gnt, req_rd_data, req_rd_data_v, mm_wr_en, mm_rd_en, mm_addr, mm_wr_data,
           timeout_cnt
  );

  modport slave (
    output req_wr_en, req_rd_en, req_addr, req_wr_data, mm_rd_data, mm_rd_data_v,
    input  req_gnt, req_rd_data, req_rd_data_v, mm_wr_en, mm_rd_en, mm_addr, mm_wr_data,
           timeout_cnt
  );
endinterface

// File: rtl/link_mm_arbiter.sv
// Round-robin arbiter sharing the link MM register bus between N_REQ requesters, one
// transaction in flight. Optional read timeout enabled by defining MM_ARB_TIMEOUT_EN.
module link_mm_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  link_mm_arbiter_if.master  bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    win_q;
  logic [IdxW-1:0]    win_d;
  logic               is_rd_q;
  logic               found;
  int                 idx;
  logic [N_REQ-1:0]   pend;
  logic [N_REQ-1:0]   win_oh_d;
  logic [N_REQ-1:0]   win_oh_q;
  logic               wr_sel;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  wdata_sel;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               mm_wr_en_q;
  logic               mm_rd_en_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [N_REQ-1:0]   rd_data_v_q;

  // Search starts just after the last granted index, so every requester gets a turn.
  always_comb begin
    pend  = bus.req_wr_en | bus.req_rd_en;
    win_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(N_REQ);
      if (!found && pend[idx]) begin
        found = 1'b1;
        win_d = IdxW'(idx);
      end
    end
  end

  assign win_oh_d  = N_REQ'(1) << win_d;
  assign win_oh_q  = N_REQ'(1) << win_q;
  assign wr_sel    = bus.req_wr_en[win_d];
  assign addr_sel  = bus.req_addr[win_d*ADDR_W +: ADDR_W];
  assign wdata_sel = bus.req_wr_data[win_d*DATA_W +: DATA_W];

`ifdef MM_ARB_TIMEOUT_EN
  logic [31:0]       to_cyc_q;
  logic [15:0]       to_total_q;
  logic [DATA_W-1:0] to_data;

  always_comb begin
    to_data                  = '0;
    to_data[ADDR_W-1:0]      = addr_q;
    to_data[DATA_W-1 -: 32]  = 32'hDEAD_BEEF;
  end

  assign bus.timeout_cnt = to_total_q;
`else
  assign bus.timeout_cnt = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(N_REQ - 1);
      win_q       <= '0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= '0;
      mm_wr_en_q  <= 1'b0;
      mm_rd_en_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_data_v_q <= '0;
`ifdef MM_ARB_TIMEOUT_EN
      to_cyc_q    <= '0;
      to_total_q  <= '0;
`endif
    end else begin
      gnt_q       <= '0;
      mm_wr_en_q  <= 1'b0;
      mm_rd_en_q  <= 1'b0;
      rd_data_v_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            // A requester holding both WR and RD gets its write first.
            win_q      <= win_d;
            is_rd_q    <= !wr_sel;
            addr_q     <= addr_sel;
            wdata_q    <= wdata_sel;
            gnt_q      <= win_oh_d;
            mm_wr_en_q <= wr_sel;
            mm_rd_en_q <= !wr_sel;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          ptr_q   <= win_q;
          state_q <= is_rd_q ? StRdWait : StIdle;
`ifdef MM_ARB_TIMEOUT_EN
          to_cyc_q <= '0;
`endif
        end
        StRdWait: begin
          if (bus.mm_rd_data_v) begin
            rd_data_q   <= bus.mm_rd_data;
            rd_data_v_q <= win_oh_q;
            state_q     <= StIdle;
          end
`ifdef MM_ARB_TIMEOUT_EN
          // ISSUE counts as the first elapsed cycle of the timeout window.
          else if (to_cyc_q >= 32'(TIMEOUT_CYC - 2)) begin
            rd_data_q   <= to_data;
            rd_data_v_q <= win_oh_q;
            state_q     <= StIdle;
            if (to_total_q != 16'hFFFF) to_total_q <= to_total_q + 16'd1;
          end else begin
            to_cyc_q <= to_cyc_q + 32'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_gnt       = gnt_q;
  assign bus.req_rd_data   = rd_data_q;
  assign bus.req_rd_data_v = rd_data_v_q;
  assign bus.mm_wr_en      = mm_wr_en_q;
  assign bus.mm_rd_en      = mm_rd_en_q;
  assign bus.mm_addr       = addr_q;
  assign bus.mm_wr_data    = wdata_q;

endmodule
